// File: rtl/bz_melody_seq_if.sv
// Bus between the note sequencer and its host / beat counter.
// master: host side (start/stop) plus the beat counter's finish pulse.
// slave : the sequencer itself.
interface bz_melody_seq_if;
  logic        start;
  logic        stop;
  logic        beat_finish;
  logic        beat_en;
  logic [27:0] beat_cnt_parameter;
  logic        tone_en;
  logic [17:0] tone_div;
  logic [3:0]  note_idx;
  logic        busy;
  logic        done;

  modport master (
    output start, stop, beat_finish,
    input  beat_en, beat_cnt_parameter, tone_en, tone_div, note_idx, busy, done
  );

  modport slave (
    input  start, stop, beat_finish,
    output beat_en, beat_cnt_parameter, tone_en, tone_div, note_idx, busy, done
  );
endinterface

// File: rtl/bz_melody_seq.sv
// Buzzer note sequencer: steps through a song ROM, programs the beat counter
// (duration/enable) and the tone generator (half-period/enable), and inserts
// a silent gap between notes.
// Build option: define BZ_LOOP_EN to loop the song forever (no done pulse).
module bz_melody_seq #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BEAT_TICKS = 12_500_000,
  parameter int unsigned GAP_TICKS  = 2_500_000,
  parameter int unsigned SONG_LEN   = 8
) (
  input logic            clk,
  input logic            rstn,
  bz_melody_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(SONG_LEN - 1);

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic [31:0] gap_cnt, gap_nx;
  logic        ben, ben_nx;
  logic [27:0] param, param_nx;
  logic        ten, ten_nx;
  logic [17:0] div, div_nx;
  logic        busy, busy_nx;
  logic        done, done_nx;

  logic [5:0]  entry;
  logic [2:0]  pitch;
  logic [2:0]  beats;

  // Song ROM entry: {pitch[2:0], beats[2:0]}
  function automatic logic [5:0] rom(input logic [3:0] i);
    case (i)
      4'd0:    rom = {3'd1, 3'd1};
      4'd1:    rom = {3'd1, 3'd1};
      4'd2:    rom = {3'd5, 3'd1};
      4'd3:    rom = {3'd5, 3'd1};
      4'd4:    rom = {3'd6, 3'd1};
      4'd5:    rom = {3'd6, 3'd1};
      4'd6:    rom = {3'd5, 3'd2};
      4'd7:    rom = {3'd0, 3'd1};
      default: rom = '0;
    endcase
  endfunction

  // Half-period divider for pitches C4..B4; pitch 0 is a rest
  function automatic logic [17:0] div_of(input logic [2:0] p);
    case (p)
      3'd1:    div_of = 18'(CLK_HZ / (2 * 262));
      3'd2:    div_of = 18'(CLK_HZ / (2 * 294));
      3'd3:    div_of = 18'(CLK_HZ / (2 * 330));
      3'd4:    div_of = 18'(CLK_HZ / (2 * 349));
      3'd5:    div_of = 18'(CLK_HZ / (2 * 392));
      3'd6:    div_of = 18'(CLK_HZ / (2 * 440));
      3'd7:    div_of = 18'(CLK_HZ / (2 * 494));
      default: div_of = '0;
    endcase
  endfunction

  assign entry = rom(idx);
  assign pitch = entry[5:3];
  assign beats = (entry[2:0] == 3'd0) ? 3'd1 : entry[2:0];

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      idx     <= '0;
      gap_cnt <= '0;
      ben     <= 1'b0;
      param   <= '0;
      ten     <= 1'b0;
      div     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      gap_cnt <= gap_nx;
      ben     <= ben_nx;
      param   <= param_nx;
      ten     <= ten_nx;
      div     <= div_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  // Next state and next output values; outputs are computed one cycle ahead
  // so that every port is a flop and reflects the state it belongs to.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    gap_nx   = gap_cnt;
    ben_nx   = ben;
    param_nx = param;
    ten_nx   = ten;
    div_nx   = div;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = LOAD;
          idx_nx   = '0;
        end
      end
      LOAD: begin
        state_nx = PLAY;
        param_nx = 28'(BEAT_TICKS * 32'(beats) - 1);
        div_nx   = div_of(pitch);
        ben_nx   = 1'b1;
        ten_nx   = (pitch != 3'd0);
      end
      PLAY: begin
        if (bus.beat_finish) begin
          state_nx = GAP;
          ben_nx   = 1'b0;
          ten_nx   = 1'b0;
          gap_nx   = '0;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_TICKS - 1) begin
          if (idx == LAST_IDX) begin
`ifdef BZ_LOOP_EN
            state_nx = LOAD;
            idx_nx   = '0;
`else
            state_nx = DONE;
`endif
          end else begin
            state_nx = LOAD;
            idx_nx   = idx + 4'd1;
          end
        end else begin
          gap_nx = gap_cnt + 32'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        idx_nx   = '0;
        param_nx = '0;
        div_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.stop) begin
      state_nx = IDLE;
      idx_nx   = '0;
      gap_nx   = '0;
      ben_nx   = 1'b0;
      param_nx = '0;
      ten_nx   = 1'b0;
      div_nx   = '0;
    end
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DONE);
  end

  assign bus.beat_en            = ben;
  assign bus.beat_cnt_parameter = param;
  assign bus.tone_en            = ten;
  assign bus.tone_div           = div;
  assign bus.note_idx           = idx;
  assign bus.busy               = busy;
  assign bus.done               = done;

endmodule
